// File: rtl/keypad_pkg.sv
// keypad_pkg: shared debounce states, op indices and event encoders for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_EQ  = 4;
  localparam int OP_AC  = 5;
  localparam int OP_NEG = 6;
  function automatic int enc_key(int code);
    return code;
  endfunction
  function automatic int enc_op(int idx, int dw);
    return (1 << (dw - 1)) | idx;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: valid/ready key event channel from scanner to calculator core
interface keypad_scanner_if #(parameter int DATA_W = 5);
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  modport master (output o_data, o_valid, input i_ready);
  modport slave  (input o_data, o_valid, output i_ready);
endinterface

// File: rtl/key_event_fifo.sv
// key_event_fifo: first-word-fall-through queue with count-based full/empty and sticky drop flag
module key_event_fifo #(
  parameter int DATA_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     rd, wr;
  logic [CW-1:0]     cnt;
  logic              full, do_pop, do_push;
  assign valid   = cnt != '0;
  assign full    = cnt == CW'(FIFO_DEPTH);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem[rd] : '0;
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr <= wr == AW'(FIFO_DEPTH - 1) ? '0 : wr + 1'b1;
      if (do_pop) rd <= rd == AW'(FIFO_DEPTH - 1) ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
      if (push && !do_push) overflow <= 1'b1;
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned key matrix plus op pins, frame-debounced into a queued key event stream
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int N_OPS          = 7,
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROWS-1:0]   o_word_lines,
  input  logic [COLS-1:0]   i_bit_lines,
  input  logic [N_OPS-1:0]  i_ops,
  output logic              o_overflow,
  keypad_scanner_if.master  ev
);
  localparam int CW     = $clog2(ROWS * COLS);
  localparam int OW     = $clog2(N_OPS);
  localparam int DATA_W = 1 + (CW > OW ? CW : OW);
  localparam int SW     = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW     = $clog2(ROWS);
  localparam int NW     = $clog2(DEBOUNCE_SCANS + 1);
  logic [SW-1:0]     sc;
  logic [RW-1:0]     r;
  logic              last, frame_end;
  logic [N_OPS-1:0]  op_mask, mask_n;
  logic              key_hit, hit_n, row_hit, pressed, push;
  logic [DATA_W-1:0] key_code, code_n, row_code, fcode, cand, cand_n;
  logic [NW-1:0]     cnt, cnt_n, cnt_inc;
  int                op_idx;
  state_t            state, state_n;
  assign last         = sc == SW'(SETTLE_CYCLES - 1);
  assign frame_end    = last && r == RW'(ROWS - 1);
  assign o_word_lines = ROWS'(1) << r;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sc <= '0;
      r  <= '0;
    end else begin
      sc <= last ? '0 : sc + 1'b1;
      if (last) r <= frame_end ? '0 : r + 1'b1;
    end
  // The current sample is folded in combinationally so the frame result is ready on the final sample edge.
  always_comb begin
    row_hit  = 1'b0;
    row_code = '0;
    op_idx   = 0;
    for (int c = 0; c < COLS; c++)
      if (i_bit_lines[c]) begin
        row_hit  = 1'b1;
        row_code = DATA_W'(int'(r) * COLS + c);
      end
    mask_n = op_mask | i_ops;
    for (int i = N_OPS - 1; i >= 0; i--)
      if (mask_n[i]) op_idx = i;
    hit_n   = key_hit | row_hit;
    code_n  = row_hit ? row_code : key_code;
    pressed = (|mask_n) || hit_n;
    fcode   = |mask_n ? DATA_W'(enc_op(op_idx, DATA_W)) : DATA_W'(enc_key(int'(code_n)));
  end
  always_ff @(posedge clk)
    if (!rst_n || (last && frame_end)) begin
      op_mask  <= '0;
      key_hit  <= 1'b0;
      key_code <= '0;
    end else if (last) begin
      op_mask  <= mask_n;
      key_hit  <= hit_n;
      key_code <= code_n;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  assign cnt_inc = cnt + 1'b1;
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    push    = 1'b0;
    if (frame_end)
      case (state)
        IDLE:
          if (pressed) begin
            cand_n  = fcode;
            cnt_n   = NW'(1);
            state_n = DEBOUNCE_SCANS == 1 ? HELD : CONFIRM;
          end
        CONFIRM:
          if (!pressed) state_n = IDLE;
          else if (fcode == cand) begin
            cnt_n   = cnt_inc;
            state_n = cnt_inc == NW'(DEBOUNCE_SCANS) ? HELD : CONFIRM;
          end else begin
            cand_n = fcode;
            cnt_n  = NW'(1);
          end
        HELD:
          if (!pressed) begin
            cnt_n   = NW'(1);
            push    = DEBOUNCE_SCANS == 1;
            state_n = DEBOUNCE_SCANS == 1 ? IDLE : RELEASE;
          end
        RELEASE:
          if (pressed) state_n = HELD;
          else begin
            cnt_n   = cnt_inc;
            push    = cnt_inc == NW'(DEBOUNCE_SCANS);
            state_n = push ? IDLE : RELEASE;
          end
        default: state_n = IDLE;
      endcase
  end
  key_event_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .din      (cand),
    .pop      (ev.i_ready),
    .dout     (ev.o_data),
    .valid    (ev.o_valid),
    .overflow (o_overflow)
  );
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, priority, queueing and reset
module tb_keypad_scanner;
  import keypad_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  word, bits;
  logic [6:0]  ops;
  logic        ovf;
  logic [15:0] keys;
  int          total = 0;
  int          bad = 0;
  keypad_scanner_if #(.DATA_W(5)) ev ();
  keypad_scanner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_word_lines (word),
    .i_bit_lines  (bits),
    .i_ops        (ops),
    .o_overflow   (ovf),
    .ev           (ev)
  );
  always #5 clk = ~clk;
  always_comb begin
    bits = '0;
    for (int r = 0; r < 4; r++)
      if (word[r]) bits = bits | keys[r*4 +: 4];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !ev.o_valid; i++) step(1);
    chk(tag, 32'(ev.o_valid), 32'd1);
  endtask
  task automatic pop1;
    ev.i_ready = 1'b1;
    step(1);
    ev.i_ready = 1'b0;
  endtask
  initial begin
    logic [3:0] wl_exp [4];
    wl_exp = '{4'd1, 4'd2, 4'd4, 4'd8};
    rst_n = 1'b0;
    keys = '0;
    ops = '0;
    ev.i_ready = 1'b0;
    step(3);
    chk("rst_word", 32'(word), 32'd1);
    chk("rst_valid", 32'(ev.o_valid), 32'd0);
    chk("rst_data", 32'(ev.o_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    // row 1 / col 2 held 3 frames, word lines checked over the first frame
    keys[6] = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("word_%0d", i), 32'(word), 32'(wl_exp[i/2]));
      step(1);
    end
    step(16);
    keys = '0;
    wait_valid("k6_valid", 64);
    chk("k6_data", 32'(ev.o_data), 32'b00110);
    step(32);
    pop1;
    chk("k6_single", 32'(ev.o_valid), 32'd0);
    // single-frame bounce
    keys[0] = 1'b1;
    step(8);
    keys = '0;
    step(8);
    chk("bounce_idle", 32'(dut.state), 32'(IDLE));
    step(32);
    chk("bounce_noevt", 32'(ev.o_valid), 32'd0);
    // op beats matrix key
    ops[OP_ADD] = 1'b1;
    keys[11] = 1'b1;
    step(24);
    ops = '0;
    keys = '0;
    wait_valid("op_valid", 64);
    chk("op_data", 32'(ev.o_data), 32'b10000);
    pop1;
    chk("op_empty", 32'(ev.o_valid), 32'd0);
    // highest matrix code wins
    keys[4] = 1'b1;
    keys[13] = 1'b1;
    step(24);
    keys = '0;
    wait_valid("multi_valid", 64);
    chk("multi_data", 32'(ev.o_data), 32'd13);
    pop1;
    chk("multi_empty", 32'(ev.o_valid), 32'd0);
    // five events into a four-deep queue
    for (int k = 1; k <= 5; k++) begin
      keys = 16'(1) << k;
      step(24);
      keys = '0;
      step(24);
    end
    chk("ovf_set", 32'(ovf), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain_valid_%0d", k), 32'(ev.o_valid), 32'd1);
      chk($sformatf("drain_data_%0d", k), 32'(ev.o_data), 32'(k));
      pop1;
    end
    chk("drain_empty", 32'(ev.o_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    // reset while held, key released during reset
    keys[6] = 1'b1;
    step(24);
    chk("held_state", 32'(dut.state), 32'(HELD));
    rst_n = 1'b0;
    keys = '0;
    step(1);
    rst_n = 1'b1;
    chk("rst2_word", 32'(word), 32'd1);
    chk("rst2_valid", 32'(ev.o_valid), 32'd0);
    chk("rst2_data", 32'(ev.o_data), 32'd0);
    chk("rst2_ovf", 32'(ovf), 32'd0);
    chk("rst2_state", 32'(dut.state), 32'(IDLE));
    step(40);
    chk("rst2_noevt", 32'(ev.o_valid), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
